// File: rtl/fsm_delay_pulse_gen.sv
// Multi-channel trigger-to-pulse generator: synchronised rising edge, programmable delay, then a programmable-width pulse.
// Optional feature macro: MISSED_TRIG_CNT_EN adds per-channel saturating counts of edges ignored while busy.
module fsm_delay_pulse_gen #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         trig_in,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH*CNT_W-1:0]   delay_cfg,
    input  logic [N_CH*CNT_W-1:0]   width_cfg,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH*CNT_W-1:0]   counter_out
`ifdef MISSED_TRIG_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   missed_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   edge_det;
        logic [1:0]             state;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       d_lat;
        logic [CNT_W-1:0]       w_lat;
        logic                   pulse_r;
        logic                   busy_r;
        logic [CNT_W-1:0]       dcfg;
        logic [CNT_W-1:0]       wcfg;

        assign dcfg = delay_cfg[i*CNT_W +: CNT_W];
        assign wcfg = width_cfg[i*CNT_W +: CNT_W];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in[i]};
            end
        end

        // Edge is flagged on the posedge that loads a 1 into the last flop over a 0,
        // so the state machine reacts on that same clock.
        assign edge_det = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                d_lat   <= '0;
                w_lat   <= '0;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else if (!enable[i]) begin
                state   <= S_IDLE;
                cnt     <= '0;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (edge_det) begin
                            d_lat <= dcfg;
                            w_lat <= wcfg;
                            cnt   <= '0;
                            if (dcfg != '0) begin
                                state  <= S_DELAY;
                                busy_r <= 1'b1;
                            end else if (wcfg != '0) begin
                                state   <= S_PULSE;
                                pulse_r <= 1'b1;
                                busy_r  <= 1'b1;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt == d_lat - ONE) begin
                            cnt <= '0;
                            if (w_lat != '0) begin
                                state   <= S_PULSE;
                                pulse_r <= 1'b1;
                            end else begin
                                state  <= S_IDLE;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_PULSE: begin
                        if (cnt == w_lat - ONE) begin
                            state   <= S_IDLE;
                            cnt     <= '0;
                            pulse_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        pulse_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end

        assign pulse_out[i]                 = pulse_r;
        assign busy[i]                      = busy_r;
        assign counter_out[i*CNT_W +: CNT_W] = cnt;

`ifdef MISSED_TRIG_CNT_EN
        logic [CNT_W-1:0] missed;

        // Any edge arriving outside IDLE is dropped; count it, saturating.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                missed <= '0;
            end else if (edge_det && (state != S_IDLE) && (missed != '1)) begin
                missed <= missed + ONE;
            end
        end

        assign missed_cnt[i*CNT_W +: CNT_W] = missed;
`endif
    end

endmodule
